cmac_msg_packer: RTL and testbench

//  Upstream feeder for CMAC_Top. Packs a byte stream with valid/ready handshake into 128-bit message blocks.

---
 rtl/cmac_msg_packer_if.sv | 28 ++
 rtl/cmac_msg_packer.sv | 160 ++++++++++++++++
 tb/tb_cmac_msg_packer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmac_msg_packer_if.sv
// Byte-stream input and CMAC_Top block-load bundle for cmac_msg_packer.
interface cmac_msg_packer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             empty_req;
    logic             Done;
    logic             ld_Block;
    logic [127:0]     TextIn;
    logic             Last_Block;
    logic [7:0]       Last_Block_Len;
    logic             tag_valid;
    logic [CNT_W-1:0] blk_cnt;
    logic [CNT_W-1:0] msg_cnt;

    modport master (
        output in_valid, in_data, in_last, empty_req, Done,
        input  in_ready, ld_Block, TextIn, Last_Block, Last_Block_Len, tag_valid, blk_cnt, msg_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, empty_req, Done,
        output in_ready, ld_Block, TextIn, Last_Block, Last_Block_Len, tag_valid, blk_cnt, msg_cnt
    );
endinterface

// File: rtl/cmac_msg_packer.sv
// Packs a valid/ready byte stream into 128-bit CMAC_Top blocks and paces issue on the core's Done.
// Optional block/tag statistics counters are built when CMAC_PKR_STATS_EN is defined.
module cmac_msg_packer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Rst,
    cmac_msg_packer_if.slave bus
);
    localparam int unsigned BLK_W = 128;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

    state_t            state, state_next;
    logic [BLK_W-1:0]  acc_data, acc_data_n, wr_data;
    logic [4:0]        acc_cnt, acc_cnt_n, wr_cnt;
    logic              acc_pend, acc_pend_n;
    logic              acc_last, acc_last_n;
    logic [BLK_W-1:0]  hold_data, hold_data_n;
    logic              hold_last, hold_last_n;
    logic [7:0]        hold_len, hold_len_n;
    logic              hold_occ, hold_occ_n;
    logic              accept, hold_avail;
    logic [6:0]        byte_pos;
    logic              load_c, tag_c;

    // Accumulator / holding-register next state; acc_pend marks a closed block stuck behind a full holding reg
    always_comb begin
        accept      = bus.in_valid & bus.in_ready;
        hold_avail  = ~hold_occ | (state == LOAD);
        acc_data_n  = acc_data;
        acc_cnt_n   = acc_cnt;
        acc_pend_n  = acc_pend;
        acc_last_n  = acc_last;
        hold_data_n = hold_data;
        hold_last_n = hold_last;
        hold_len_n  = hold_len;
        hold_occ_n  = hold_occ & (state != LOAD);
        byte_pos    = 7'd120 - {acc_cnt[3:0], 3'b000};
        wr_cnt      = acc_cnt + 5'd1;
        wr_data     = acc_data;
        wr_data[byte_pos +: 8] = bus.in_data;

        if (acc_pend) begin
            if (hold_avail) begin
                hold_data_n = acc_data;
                hold_last_n = acc_last;
                hold_len_n  = {acc_cnt, 3'b000};
                hold_occ_n  = 1'b1;
                acc_data_n  = '0;
                acc_cnt_n   = 5'd0;
                acc_pend_n  = 1'b0;
                acc_last_n  = 1'b0;
            end
        end else if (accept) begin
            if (bus.in_last || (acc_cnt == 5'd15)) begin
                if (hold_avail) begin
                    hold_data_n = wr_data;
                    hold_last_n = bus.in_last;
                    hold_len_n  = {wr_cnt, 3'b000};
                    hold_occ_n  = 1'b1;
                    acc_data_n  = '0;
                    acc_cnt_n   = 5'd0;
                end else begin
                    acc_data_n  = wr_data;
                    acc_cnt_n   = wr_cnt;
                    acc_pend_n  = 1'b1;
                    acc_last_n  = bus.in_last;
                end
            end else begin
                acc_data_n = wr_data;
                acc_cnt_n  = wr_cnt;
            end
        end else if (bus.empty_req && (acc_cnt == 5'd0) && !hold_occ) begin
            hold_data_n = '0;
            hold_last_n = 1'b1;
            hold_len_n  = 8'd0;
            hold_occ_n  = 1'b1;
        end
    end

    // Issue FSM; a pending block after Done falls goes straight to LOAD
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        tag_c      = 1'b0;
        case (state)
            IDLE:    if (hold_occ) state_next = LOAD;
            LOAD:    state_next = WAIT_HI;
            WAIT_HI: if (bus.Done) state_next = WAIT_LO;
            WAIT_LO: if (!bus.Done) begin
                state_next = hold_occ ? LOAD : IDLE;
                tag_c      = bus.Last_Block;
            end
            default: state_next = IDLE;
        endcase
        load_c = (state_next == LOAD);
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            acc_data           <= '0;
            acc_cnt            <= 5'd0;
            acc_pend           <= 1'b0;
            acc_last           <= 1'b0;
            hold_data          <= '0;
            hold_last          <= 1'b0;
            hold_len           <= 8'd0;
            hold_occ           <= 1'b0;
            bus.in_ready       <= 1'b1;
            bus.ld_Block       <= 1'b0;
            bus.TextIn         <= '0;
            bus.Last_Block     <= 1'b0;
            bus.Last_Block_Len <= 8'd0;
            bus.tag_valid      <= 1'b0;
        end else begin
            acc_data           <= acc_data_n;
            acc_cnt            <= acc_cnt_n;
            acc_pend           <= acc_pend_n;
            acc_last           <= acc_last_n;
            hold_data          <= hold_data_n;
            hold_last          <= hold_last_n;
            hold_len           <= hold_len_n;
            hold_occ           <= hold_occ_n;
            bus.in_ready       <= ~acc_pend_n;
            bus.ld_Block       <= load_c;
            bus.tag_valid      <= tag_c;
            if (load_c) begin
                bus.TextIn         <= hold_data;
                bus.Last_Block     <= hold_last;
                bus.Last_Block_Len <= hold_len;
            end
        end
    end

`ifdef CMAC_PKR_STATS_EN
    logic [CNT_W-1:0] blk_q, msg_q;

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            blk_q <= '0;
            msg_q <= '0;
        end else begin
            if (bus.ld_Block)  blk_q <= blk_q + CNT_W'(1);
            if (bus.tag_valid) msg_q <= msg_q + CNT_W'(1);
        end
    end

    assign bus.blk_cnt = blk_q;
    assign bus.msg_cnt = msg_q;
`else
    assign bus.blk_cnt = CNT_W'(0);
    assign bus.msg_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_cmac_msg_packer.sv
// Self-checking bench for cmac_msg_packer: directed NIST/empty/stall/reset steps plus random messages
// checked against a block-splitting reference model and an emulated CMAC_Top Done handshake.
module tb_cmac_msg_packer;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [7:0]   len;
    } blk_t;

    logic CLK = 1'b0;
    logic Rst;

    cmac_msg_packer_if #(.CNT_W(CNT_W)) bus ();
    cmac_msg_packer #(.CNT_W(CNT_W)) dut (.CLK(CLK), .Rst(Rst), .bus(bus));

    always #5 CLK = ~CLK;

    int   checks = 0, errors = 0;
    int   cyc = 0;
    blk_t sb[$];
    int   exp_tags = 0, tag_seen = 0;
    int   exp_blk = 0, exp_msg = 0;
    int   acc_total = 0, last_acc_cyc = 0, last_ld_cyc = 0;
    int   stall_base = 0;
    bit   core_busy = 1'b0, stall_mode = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (bus.tag_valid === 1'b1) tag_seen++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a message becomes ceil(n/16) left-aligned zero-padded blocks, or one empty last block
    function automatic void push_msg(input logic [7:0] b[$]);
        blk_t e;
        int   n;
        exp_tags++;
        exp_msg++;
        if (b.size() == 0) begin
            e.data = '0;
            e.last = 1'b1;
            e.len  = 8'd0;
            sb.push_back(e);
            exp_blk++;
            return;
        end
        for (int s = 0; s < b.size(); s += 16) begin
            n = (b.size() - s < 16) ? b.size() - s : 16;
            e.data = '0;
            for (int j = 0; j < n; j++) e.data = {e.data[119:0], b[s+j]};
            e.data = e.data << (8 * (16 - n));
            e.last = (s + n == b.size());
            e.len  = 8'(8 * n);
            sb.push_back(e);
            exp_blk++;
        end
    endfunction

    task automatic send(input logic [7:0] b[$], input bit with_last, input int gap_pct, input bit with_empty);
        int i = 0;
        int budget = 0;
        while (i < b.size() && budget < 5000) begin
            @(negedge CLK);
            budget++;
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid  = 1'b0;
                bus.in_last   = 1'b0;
                bus.empty_req = 1'b0;
            end else begin
                bus.in_valid  = 1'b1;
                bus.in_data   = b[i];
                bus.in_last   = with_last && (i == b.size() - 1);
                bus.empty_req = with_empty && (i == 0);
                if (bus.in_ready === 1'b1) begin
                    i++;
                    acc_total++;
                    last_acc_cyc = cyc;
                end
            end
        end
        checks++;
        assert (i == b.size()) else begin
            errors++;
            $error("FAIL send_timeout: sent %0d expected %0d", i, b.size());
        end
        @(negedge CLK);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.empty_req = 1'b0;
    endtask

    task automatic pulse_empty();
        @(negedge CLK);
        bus.empty_req = 1'b1;
        @(negedge CLK);
        bus.empty_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || core_busy) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        assert (n < 3000) else begin
            errors++;
            $error("FAIL %s_timeout: observed %0d blocks outstanding expected 0", tag, sb.size());
        end
        repeat (4) @(negedge CLK);
    endtask

    // CMAC_Top emulation: checks each load, raises then drops Done, checks the tag pulse
    initial begin : core
        blk_t e;
        logic cur_last;
        int   d1, d2;
        bit   stalled;
        bus.Done = 1'b0;
        @(negedge CLK);
        forever begin
            if (bus.ld_Block === 1'b1) begin
                core_busy   = 1'b1;
                last_ld_cyc = cyc;
                cur_last    = bus.Last_Block;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_load: observed TextIn %0h expected no load", bus.TextIn);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("TextIn", bus.TextIn, e.data);
                    chk("Last_Block", 128'(bus.Last_Block), 128'(e.last));
                    chk("Last_Block_Len", 128'(bus.Last_Block_Len), 128'(e.len));
                end
                stalled = stall_mode;
                d1 = stalled ? 1 : int'($urandom_range(1, 4));
                d2 = stalled ? 50 : int'($urandom_range(1, 6));
                @(negedge CLK);
                chk("ld_one_cycle", 128'(bus.ld_Block), 128'(1'b0));
                repeat (d1 - 1) @(negedge CLK);
                bus.Done = 1'b1;
                repeat (d2) @(negedge CLK);
                bus.Done = 1'b0;
                if (stalled) begin
                    chk("stall_bytes", 128'(acc_total - stall_base), 128'(48));
                    chk("stall_in_ready", 128'(bus.in_ready), 128'(1'b0));
                end
                @(negedge CLK);
                chk("tag_valid", 128'(bus.tag_valid), 128'(cur_last));
                if (stalled) begin
                    chk("b2b_load", 128'(bus.ld_Block), 128'(1'b1));
                    stall_mode = 1'b0;
                end
                core_busy = 1'b0;
            end else begin
                @(negedge CLK);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [319:0] nist;
        logic [7:0]   q[$];
        logic [7:0]   q2[$];
        logic [7:0]   qa[$];
        int           len;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.in_last   = 1'b0;
        bus.empty_req = 1'b0;
        Rst  = 1'b1;
        nist = 320'h6bc1bee22e409f96e93d7e117393172aae2d8a571e03ac9c9eb76fac45af8e5130c81c46a35ce411;
        repeat (3) @(negedge CLK);

        chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
        chk("rst_ld_Block", 128'(bus.ld_Block), 128'(1'b0));
        chk("rst_TextIn", bus.TextIn, 128'(0));
        chk("rst_Last_Block", 128'(bus.Last_Block), 128'(1'b0));
        chk("rst_Last_Block_Len", 128'(bus.Last_Block_Len), 128'(0));
        chk("rst_tag_valid", 128'(bus.tag_valid), 128'(1'b0));
        chk("rst_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        chk("rst_msg_cnt", 128'(bus.msg_cnt), 128'(0));
        Rst = 1'b0;
        repeat (2) @(negedge CLK);

        // Single full NIST block, also checks accept-to-load latency
        q.delete();
        for (int k = 0; k < 16; k++) q.push_back(nist[319 - 8*k -: 8]);
        push_msg(q);
        send(q, 1'b1, 0, 1'b0);
        wait_idle("t1");
        chk("t1_latency", 128'(last_ld_cyc - last_acc_cyc), 128'(2));
        chk("t1_tags", 128'(tag_seen), 128'(exp_tags));

        // Zero-length message
        q.delete();
        push_msg(q);
        pulse_empty();
        wait_idle("t2");
        chk("t2_tags", 128'(tag_seen), 128'(exp_tags));

        // empty_req ignored while a partial block sits in the accumulator
        q.delete(); q2.delete(); qa.delete();
        for (int k = 0; k < 5; k++) begin
            q.push_back(8'($urandom));
            q2.push_back(8'($urandom));
        end
        qa = {q, q2};
        push_msg(qa);
        send(q, 1'b0, 0, 1'b0);
        pulse_empty();
        send(q2, 1'b1, 0, 1'b0);
        wait_idle("t2b");

        // 40-byte NIST message: three loads, one tag
        q.delete();
        for (int k = 0; k < 40; k++) q.push_back(nist[319 - 8*k -: 8]);
        push_msg(q);
        send(q, 1'b1, 0, 1'b0);
        wait_idle("t3");
        chk("t3_tags", 128'(tag_seen), 128'(exp_tags));

        // Core stalls 50 cycles on block 1: holding reg plus accumulator absorb exactly 48 bytes
        q.delete();
        for (int k = 0; k < 64; k++) q.push_back(8'($urandom));
        push_msg(q);
        stall_base = acc_total;
        stall_mode = 1'b1;
        send(q, 1'b1, 0, 1'b0);
        wait_idle("t4");
        chk("t4_stall_done", 128'(stall_mode), 128'(1'b0));

        // Reset mid-block discards the partial block
        q.delete();
        for (int k = 0; k < 7; k++) q.push_back(8'($urandom));
        send(q, 1'b0, 0, 1'b0);
        @(negedge CLK);
        Rst = 1'b1;
        exp_blk = 0;
        exp_msg = 0;
        @(negedge CLK);
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
        chk("mid_rst_TextIn", bus.TextIn, 128'(0));
        chk("mid_rst_Last_Block", 128'(bus.Last_Block), 128'(1'b0));
        chk("mid_rst_Last_Block_Len", 128'(bus.Last_Block_Len), 128'(0));
        chk("mid_rst_ld_Block", 128'(bus.ld_Block), 128'(1'b0));
        chk("mid_rst_tag_valid", 128'(bus.tag_valid), 128'(1'b0));
        @(negedge CLK);
        Rst = 1'b0;
        @(negedge CLK);
        q.delete();
        for (int k = 0; k < 16; k++) q.push_back(8'($urandom));
        push_msg(q);
        send(q, 1'b1, 0, 1'b0);
        wait_idle("t5");
        chk("t5_tags", 128'(tag_seen), 128'(exp_tags));

        // Random messages with source gaps and random core timing
        for (int m = 0; m < 8; m++) begin
            len = (m == 3) ? 0 : int'($urandom_range(0, 50));
            q.delete();
            if (len == 0) begin
                wait_idle("rnd_pre_empty");
                push_msg(q);
                pulse_empty();
            end else begin
                for (int k = 0; k < len; k++) q.push_back(8'($urandom));
                push_msg(q);
                send(q, 1'b1, 30, 1'($urandom_range(1)));
            end
        end
        wait_idle("rnd");

        chk("final_tags", 128'(tag_seen), 128'(exp_tags));
`ifdef CMAC_PKR_STATS_EN
        chk("blk_cnt", 128'(bus.blk_cnt), 128'(exp_blk));
        chk("msg_cnt", 128'(bus.msg_cnt), 128'(exp_msg));
`else
        chk("blk_cnt", 128'(bus.blk_cnt), 128'(0));
        chk("msg_cnt", 128'(bus.msg_cnt), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
